// File: rtl/xike_pkg.sv
// Shared constants and helpers for the mua_comb frame path.
package xike_pkg;

  localparam int unsigned NUM_BANK = 5;
  localparam int unsigned NUM_CH   = 32;
  localparam int unsigned DW       = 32;
  localparam int unsigned CW       = 12;
  localparam int unsigned IDX_W    = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } buf_state_t;

  typedef struct packed {
    logic [CW-1:0]    bank;
    logic [IDX_W-1:0] idx;
  } ch_split_t;

  // NUM_CH is a power of two, so the split is a plain bit slice.
  function automatic ch_split_t ch_split(input logic [CW-1:0] ch);
    ch_split_t r;
    r.bank = ch >> IDX_W;
    r.idx  = ch[IDX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/mua_comb_bank_buf.sv
// One bank of the ping-pong frame store: two NUM_CH-deep RAMs selected by
// buffer bit, per-slot written masks, and a registered read port.
module mua_comb_bank_buf #(
  parameter  int unsigned NUM_CH = 32,
  parameter  int unsigned DW     = 32,
  localparam int unsigned IW     = $clog2(NUM_CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          wr_buf,
  input  logic [IW-1:0] wr_idx,
  input  logic [DW-1:0] wr_data,
  input  logic          clr_en,
  input  logic          clr_buf,
  input  logic          rd_en,
  input  logic          rd_buf,
  input  logic [IW-1:0] rd_idx,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0]     ram  [2*NUM_CH];
  logic [NUM_CH-1:0] mask [2];

  always_ff @(posedge clk) begin
    if (wr_en) ram[{wr_buf, wr_idx}] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask[0] <= '0;
      mask[1] <= '0;
    end else begin
      if (clr_en) mask[clr_buf] <= '0;
      if (wr_en)  mask[wr_buf][wr_idx] <= 1'b1;
    end
  end

  // Unwritten slots read as zero; the output is also zero between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en && mask[rd_buf][rd_idx]) begin
      rd_data <= ram[{rd_buf, rd_idx}];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/mua_comb_tx.sv
// Frame assembler/transmitter: buffers one sample per cycle by global channel
// and replays each frame as NUM_CH beats of NUM_BANK parallel channels.
module mua_comb_tx #(
  parameter int unsigned NUM_BANK = xike_pkg::NUM_BANK,
  parameter int unsigned NUM_CH   = xike_pkg::NUM_CH,
  parameter int unsigned DW       = xike_pkg::DW,
  parameter int unsigned CW       = xike_pkg::CW
) (
  input  logic                   bus_clk,
  input  logic                   bus_rst_n,
  input  logic                   tx_en,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [CW-1:0]          s_ch,
  input  logic [DW-1:0]          s_data,
  input  logic                   s_eof,
  output logic                   mua_comb_valid,
  output logic [NUM_BANK*CW-1:0] mua_comb_ch,
  output logic [NUM_BANK*DW-1:0] mua_comb_data,
  output logic                   mua_comb_eof,
  output logic [15:0]            frame_cnt,
  output logic                   err_ch
);

  import xike_pkg::*;

  localparam int unsigned IW       = $clog2(NUM_CH);
  localparam int unsigned NUM_SLOT = NUM_BANK * NUM_CH;

  localparam logic [0:0] W_FILL  = 1'b0;
  localparam logic [0:0] W_STALL = 1'b1;
  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_RUN   = 1'b1;

  logic [0:0]  w_state;
  logic        wr_ptr;
  buf_state_t  buf_st [2];

  logic [0:0]  rd_state;
  logic        rd_buf;
  logic [IW-1:0] rd_idx;
  logic        out_buf;

  ch_split_t   sp;
  logic        in_range, xfer, eof_xfer, free_now, other_free;
  logic [1:0]  elig;
  logic        start, start_buf, issue, issue_buf, last_issue, chain;
  logic [IW-1:0] issue_idx;

  assign s_ready  = (w_state == W_FILL);
  assign xfer     = s_valid & s_ready;
  assign eof_xfer = xfer & s_eof;
  assign sp       = ch_split(s_ch);
  assign in_range = (s_ch < CW'(NUM_SLOT));

  // A buffer is released on the cycle its last beat is on the output.
  assign free_now   = mua_comb_valid & mua_comb_eof;
  assign other_free = (buf_st[~wr_ptr] == EMPTY) | (free_now & (out_buf == ~wr_ptr));

  // The buffer whose last beat is still on the output must not be restarted.
  assign elig[0] = (buf_st[0] == FULL) & ~(mua_comb_valid & ~out_buf);
  assign elig[1] = (buf_st[1] == FULL) & ~(mua_comb_valid &  out_buf);

  assign start      = (rd_state == R_IDLE) & tx_en & (|elig);
  assign start_buf  = elig[~wr_ptr] ? ~wr_ptr : wr_ptr;
  assign issue      = start | (rd_state == R_RUN);
  assign issue_buf  = (rd_state == R_RUN) ? rd_buf : start_buf;
  assign issue_idx  = (rd_state == R_RUN) ? rd_idx : '0;
  assign last_issue = issue & (issue_idx == IW'(NUM_CH - 1));
  assign chain      = tx_en & elig[~issue_buf];

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      w_state   <= W_FILL;
      wr_ptr    <= 1'b0;
      buf_st[0] <= EMPTY;
      buf_st[1] <= EMPTY;
    end else begin
      if (free_now) buf_st[out_buf] <= EMPTY;
      if (xfer && in_range && buf_st[wr_ptr] == EMPTY) buf_st[wr_ptr] <= FILLING;
      if (eof_xfer) buf_st[wr_ptr] <= FULL;
      case (w_state)
        W_FILL: begin
          if (eof_xfer) begin
            if (other_free) wr_ptr  <= ~wr_ptr;
            else            w_state <= W_STALL;
          end
        end
        default: begin
          if (other_free) begin
            wr_ptr  <= ~wr_ptr;
            w_state <= W_FILL;
          end
        end
      endcase
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      rd_state       <= R_IDLE;
      rd_buf         <= 1'b0;
      rd_idx         <= '0;
      out_buf        <= 1'b0;
      mua_comb_valid <= 1'b0;
      mua_comb_eof   <= 1'b0;
      mua_comb_ch    <= '0;
      frame_cnt      <= '0;
      err_ch         <= 1'b0;
    end else begin
      err_ch         <= xfer & ~in_range;
      mua_comb_valid <= issue;
      mua_comb_eof   <= last_issue;
      out_buf        <= issue_buf;
      if (free_now) frame_cnt <= frame_cnt + 16'd1;
      for (int unsigned b = 0; b < NUM_BANK; b++) begin
        mua_comb_ch[b*CW +: CW] <= issue ? CW'(b * NUM_CH + issue_idx) : '0;
      end
      if (issue) begin
        if (last_issue) begin
          if (chain) begin
            rd_state <= R_RUN;
            rd_buf   <= ~issue_buf;
            rd_idx   <= '0;
          end else begin
            rd_state <= R_IDLE;
          end
        end else begin
          rd_state <= R_RUN;
          rd_buf   <= issue_buf;
          rd_idx   <= issue_idx + IW'(1);
        end
      end
    end
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    logic bank_wr;
    assign bank_wr = xfer & in_range & (sp.bank == CW'(b));

    mua_comb_bank_buf #(
      .NUM_CH (NUM_CH),
      .DW     (DW)
    ) u_buf (
      .clk     (bus_clk),
      .rst_n   (bus_rst_n),
      .wr_en   (bank_wr),
      .wr_buf  (wr_ptr),
      .wr_idx  (sp.idx),
      .wr_data (s_data),
      .clr_en  (free_now),
      .clr_buf (out_buf),
      .rd_en   (issue),
      .rd_buf  (issue_buf),
      .rd_idx  (issue_idx),
      .rd_data (mua_comb_data[b*DW +: DW])
    );
  end

endmodule

// File: tb/tb_mua_comb_tx.sv
// Directed scoreboard bench for mua_comb_tx.
module tb_mua_comb_tx;

  localparam int unsigned SL = 160;

  logic         bus_clk = 1'b0;
  logic         bus_rst_n = 1'b0;
  logic         tx_en = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [11:0]  s_ch = '0;
  logic [31:0]  s_data = '0;
  logic         s_eof = 1'b0;
  logic         mua_comb_valid;
  logic [59:0]  mua_comb_ch;
  logic [159:0] mua_comb_data;
  logic         mua_comb_eof;
  logic [15:0]  frame_cnt;
  logic         err_ch;

  mua_comb_tx dut (
    .bus_clk        (bus_clk),
    .bus_rst_n      (bus_rst_n),
    .tx_en          (tx_en),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_ch           (s_ch),
    .s_data         (s_data),
    .s_eof          (s_eof),
    .mua_comb_valid (mua_comb_valid),
    .mua_comb_ch    (mua_comb_ch),
    .mua_comb_data  (mua_comb_data),
    .mua_comb_eof   (mua_comb_eof),
    .frame_cnt      (frame_cnt),
    .err_ch         (err_ch)
  );

  always #5 bus_clk = ~bus_clk;

  typedef struct packed {
    logic [159:0] data;
    logic [59:0]  ch;
    logic         eof;
  } beat_t;

  beat_t       sb [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          frames_sent = 0;
  logic [31:0] cur_mem [SL];
  bit          cur_wr  [SL];

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge bus_clk);
    #1;
  endtask

  task automatic clear_model;
    for (int k = 0; k < SL; k++) cur_wr[k] = 1'b0;
  endtask

  task automatic push_frame;
    for (int i = 0; i < 32; i++) begin
      beat_t bt;
      bt = '0;
      for (int b = 0; b < 5; b++) begin
        int k;
        k = b * 32 + i;
        if (cur_wr[k]) bt.data[b*32 +: 32] = cur_mem[k];
        bt.ch[b*12 +: 12] = 12'(k);
      end
      bt.eof = (i == 31);
      sb.push_back(bt);
    end
    clear_model();
    frames_sent++;
  endtask

  task automatic send(input int ch, input logic [31:0] d, input logic eof);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_ch    = 12'(ch);
    s_data  = d;
    s_eof   = eof;
    while (!s_ready && n < 200) begin
      tick();
      n++;
    end
    if (!s_ready) chk("send_ready", s_ready, 1'b1);
    tick();
    if (ch < SL) begin
      cur_mem[ch] = d;
      cur_wr[ch]  = 1'b1;
    end
    if (eof) push_frame();
    s_valid = 1'b0;
    s_eof   = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    tick();
    tick();
    chk("frame_cnt", frame_cnt, 16'(frames_sent));
  endtask

  task automatic wait_last;
    int n;
    n = 0;
    while (!(mua_comb_valid && mua_comb_eof) && n < 200) begin
      tick();
      n++;
    end
    chk("last_beat_seen", {mua_comb_valid, mua_comb_eof}, 2'b11);
  endtask

  always @(negedge bus_clk) begin
    if (bus_rst_n === 1'b1 && mua_comb_valid === 1'b1) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_beat: observed ch %0h expected no beat", mua_comb_ch);
      end
      if (sb.size() != 0) begin
        beat_t e;
        e = sb.pop_front();
        chk("beat_data", mua_comb_data, e.data);
        chk("beat_ch", mua_comb_ch, e.ch);
        chk("beat_eof", mua_comb_eof, e.eof);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) tick();
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_valid", mua_comb_valid, 1'b0);
    chk("rst_data", mua_comb_data, '0);
    chk("rst_ch", mua_comb_ch, '0);
    chk("rst_eof", mua_comb_eof, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 16'd0);
    chk("rst_err_ch", err_ch, 1'b0);
    bus_rst_n = 1'b1;
    tick();

    // 1: full frame, ch k carries k*16
    tx_en = 1'b1;
    for (int k = 0; k < 160; k++) send(k, 32'(k * 16), k == 159);
    chk("t1_lat_1", mua_comb_valid, 1'b0);
    tick();
    chk("t1_lat_2", mua_comb_valid, 1'b1);
    drain();

    // 2: sparse frame
    send(5, 32'hAA, 1'b0);
    send(70, 32'hBB, 1'b1);
    drain();

    // 4: out-of-range channel
    send(160, 32'h55, 1'b0);
    chk("t4_err_pulse", err_ch, 1'b1);
    tick();
    chk("t4_err_clear", err_ch, 1'b0);
    send(3, 32'h33, 1'b1);
    chk("t4_err_inrange", err_ch, 1'b0);
    drain();

    // 5: eof lands on the other buffer's last beat
    send(159, 32'hA159, 1'b1);
    send(1, 32'h11, 1'b0);
    send(100, 32'h22, 1'b0);
    wait_last();
    chk("t5_ready_at_last", s_ready, 1'b1);
    send(2, 32'h77, 1'b1);
    chk("t5_ready_after", s_ready, 1'b1);
    chk("t5_gap", mua_comb_valid, 1'b0);
    tick();
    chk("t5_next_start", mua_comb_valid, 1'b1);
    drain();

    // 3: two frames held with tx_en=0, third stalls
    tx_en = 1'b0;
    send(10, 32'h1010, 1'b0);
    send(150, 32'h1150, 1'b1);
    send(31, 32'h2031, 1'b0);
    send(32, 32'h2032, 1'b1);
    chk("t3_stall", s_ready, 1'b0);
    s_valid = 1'b1;
    s_ch    = 12'd7;
    s_data  = 32'h3007;
    s_eof   = 1'b1;
    repeat (5) tick();
    chk("t3_still_stall", s_ready, 1'b0);
    chk("t3_no_tx", mua_comb_valid, 1'b0);
    tx_en = 1'b1;
    wait_last();
    chk("t3_stall_at_last", s_ready, 1'b0);
    tick();
    chk("t3_ready_after_last", s_ready, 1'b1);
    chk("t3_back_to_back", mua_comb_valid, 1'b1);
    tick();
    cur_mem[7] = 32'h3007;
    cur_wr[7]  = 1'b1;
    push_frame();
    s_valid = 1'b0;
    s_eof   = 1'b0;
    tx_en   = 1'b0;
    repeat (5) tick();
    chk("t3_no_interrupt", mua_comb_valid, 1'b1);
    wait_last();
    repeat (3) tick();
    chk("t3_hold_txen", mua_comb_valid, 1'b0);
    tx_en = 1'b1;
    drain();

    // 6: reset in the middle of a frame
    for (int k = 0; k < 160; k++) send(k, 32'h600 + 32'(k), k == 159);
    n = 0;
    while (!(mua_comb_valid && mua_comb_ch[11:0] == 12'd10) && n < 100) begin
      tick();
      n++;
    end
    chk("t6_beat10_seen", mua_comb_ch[11:0], 12'd10);
    bus_rst_n = 1'b0;
    #1;
    chk("t6_valid_drop", mua_comb_valid, 1'b0);
    chk("t6_frame_cnt", frame_cnt, 16'd0);
    sb.delete();
    clear_model();
    frames_sent = 0;
    repeat (3) tick();
    bus_rst_n = 1'b1;
    repeat (40) tick();
    chk("t6_quiet", mua_comb_valid, 1'b0);
    chk("t6_ready", s_ready, 1'b1);
    send(42, 32'hC0DE, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
